// File: rtl/ctrl_pkg.sv
// Shared constants and pipeline-control types for the decode/hazard slice.
// Bubble constants are all-zero bundles injected on stall and flush.
package ctrl_pkg;

    localparam logic [6:0] OpcRtype  = 7'b0110011;
    localparam logic [6:0] OpcItype  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluRtype = 2'b10;

    typedef enum logic [1:0] {
        FwdRf  = 2'b00,
        FwdWb  = 2'b01,
        FwdMem = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic alu_src;
        logic branch;
        logic jump;
        logic mem_read;
        logic mem_write;
        logic mem_2_reg;
        logic reg_write;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic branch;
        logic jump;
        logic mem_read;
        logic mem_write;
        logic mem_2_reg;
        logic reg_write;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic mem_2_reg;
        logic reg_write;
    } mem_wb_ctrl_t;

    localparam id_ex_ctrl_t  IdExBubble  = '0;
    localparam ex_mem_ctrl_t ExMemBubble = '0;
    localparam mem_wb_ctrl_t MemWbBubble = '0;

endpackage

// File: rtl/ctrl_pipe_hazard_if.sv
// Bundle between the control unit, the hazard/pipeline block and the datapath.
// slave = the hazard block's view; master = the surrounding decode/datapath view.
interface ctrl_pipe_hazard_if #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned ALU_OP_W = 2,
    parameter int unsigned CNT_W    = 16
);
    logic                id_valid;
    logic [ALU_OP_W-1:0] id_alu_op;
    logic                id_alu_src, id_branch, id_jump, id_mem_read;
    logic                id_mem_write, id_mem_2_reg, id_reg_write;
    logic [REG_AW-1:0]   id_rs1, id_rs2, id_rd;
    logic                flush;

    logic                stall;
    logic [ALU_OP_W-1:0] ex_alu_op;
    logic                ex_alu_src, ex_branch, ex_jump, ex_mem_read;
    logic                ex_mem_write, ex_mem_2_reg, ex_reg_write;
    logic [REG_AW-1:0]   ex_rs1, ex_rs2, ex_rd;
    logic                mem_branch, mem_jump, mem_mem_read, mem_mem_write;
    logic                mem_mem_2_reg, mem_reg_write;
    logic [REG_AW-1:0]   mem_rd;
    logic                wb_mem_2_reg, wb_reg_write;
    logic [REG_AW-1:0]   wb_rd;
    logic [1:0]          fwd_a, fwd_b;
    logic [CNT_W-1:0]    stall_cnt;

    modport slave (
        input  id_valid, id_alu_op, id_alu_src, id_branch, id_jump, id_mem_read,
               id_mem_write, id_mem_2_reg, id_reg_write, id_rs1, id_rs2, id_rd, flush,
        output stall, ex_alu_op, ex_alu_src, ex_branch, ex_jump, ex_mem_read,
               ex_mem_write, ex_mem_2_reg, ex_reg_write, ex_rs1, ex_rs2, ex_rd,
               mem_branch, mem_jump, mem_mem_read, mem_mem_write, mem_mem_2_reg,
               mem_reg_write, mem_rd, wb_mem_2_reg, wb_reg_write, wb_rd,
               fwd_a, fwd_b, stall_cnt
    );

    modport master (
        output id_valid, id_alu_op, id_alu_src, id_branch, id_jump, id_mem_read,
               id_mem_write, id_mem_2_reg, id_reg_write, id_rs1, id_rs2, id_rd, flush,
        input  stall, ex_alu_op, ex_alu_src, ex_branch, ex_jump, ex_mem_read,
               ex_mem_write, ex_mem_2_reg, ex_reg_write, ex_rs1, ex_rs2, ex_rd,
               mem_branch, mem_jump, mem_mem_read, mem_mem_write, mem_mem_2_reg,
               mem_reg_write, mem_rd, wb_mem_2_reg, wb_reg_write, wb_rd,
               fwd_a, fwd_b, stall_cnt
    );

endinterface

// File: rtl/fwd_unit.sv
// Operand forwarding select for one EX source register.
// The younger EX/MEM result wins over MEM/WB; x0 is never forwarded.
module fwd_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              mem_reg_write_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              wb_reg_write_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [REG_AW-1:0] rs_i,
    output logic [1:0]        fwd_o
);

    always_comb begin
        fwd_o = FwdRf;
        if (mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == rs_i)) begin
            fwd_o = FwdMem;
        end else if (wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == rs_i)) begin
            fwd_o = FwdWb;
        end
    end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// ID/EX, EX/MEM and MEM/WB control registers with load-use stall, flush
// bubbling, stall-cycle counter and EX-stage forwarding selects.
module ctrl_pipe_hazard
    import ctrl_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned ALU_OP_W = 2,
    parameter int unsigned CNT_W    = 16
) (
    input logic              clk,
    input logic              arst_n,
    ctrl_pipe_hazard_if.slave bus
);

    logic use_rs1, use_rs2, hz, stall;

    id_ex_ctrl_t         ex_ctrl_d, ex_ctrl_q;
    logic [ALU_OP_W-1:0] ex_alu_op_d, ex_alu_op_q;
    logic [REG_AW-1:0]   ex_rs1_d, ex_rs1_q, ex_rs2_d, ex_rs2_q, ex_rd_d, ex_rd_q;
    ex_mem_ctrl_t        mem_ctrl_d, mem_ctrl_q;
    logic [REG_AW-1:0]   mem_rd_d, mem_rd_q;
    mem_wb_ctrl_t        wb_ctrl_d, wb_ctrl_q;
    logic [REG_AW-1:0]   wb_rd_d, wb_rd_q;
    logic [CNT_W-1:0]    stall_cnt_d, stall_cnt_q;

    // Jumps carry no register sources; stores read rs2 despite alu_src=1.
    always_comb begin
        use_rs1 = ~bus.id_jump;
        use_rs2 = (~bus.id_alu_src & ~bus.id_jump) | bus.id_mem_write;
        hz      = bus.id_valid & ex_ctrl_q.mem_read & (ex_rd_q != '0) &
                  ((use_rs1 & (ex_rd_q == bus.id_rs1)) |
                   (use_rs2 & (ex_rd_q == bus.id_rs2)));
        stall   = hz & ~bus.flush;
    end

    always_comb begin
        ex_ctrl_d   = IdExBubble;
        ex_alu_op_d = '0;
        ex_rs1_d    = '0;
        ex_rs2_d    = '0;
        ex_rd_d     = '0;
        if (bus.id_valid && !stall && !bus.flush) begin
            ex_ctrl_d.alu_src   = bus.id_alu_src;
            ex_ctrl_d.branch    = bus.id_branch;
            ex_ctrl_d.jump      = bus.id_jump;
            ex_ctrl_d.mem_read  = bus.id_mem_read;
            ex_ctrl_d.mem_write = bus.id_mem_write;
            ex_ctrl_d.mem_2_reg = bus.id_mem_2_reg;
            ex_ctrl_d.reg_write = bus.id_reg_write;
            ex_alu_op_d         = bus.id_alu_op;
            ex_rs1_d            = bus.id_rs1;
            ex_rs2_d            = bus.id_rs2;
            ex_rd_d             = bus.id_rd;
        end
    end

    always_comb begin
        mem_ctrl_d = ExMemBubble;
        mem_rd_d   = '0;
        if (!bus.flush) begin
            mem_ctrl_d.branch    = ex_ctrl_q.branch;
            mem_ctrl_d.jump      = ex_ctrl_q.jump;
            mem_ctrl_d.mem_read  = ex_ctrl_q.mem_read;
            mem_ctrl_d.mem_write = ex_ctrl_q.mem_write;
            mem_ctrl_d.mem_2_reg = ex_ctrl_q.mem_2_reg;
            mem_ctrl_d.reg_write = ex_ctrl_q.reg_write;
            mem_rd_d             = ex_rd_q;
        end
    end

    // MEM/WB always advances so the flushing branch/jump still retires.
    always_comb begin
        wb_ctrl_d           = MemWbBubble;
        wb_ctrl_d.mem_2_reg = mem_ctrl_q.mem_2_reg;
        wb_ctrl_d.reg_write = mem_ctrl_q.reg_write;
        wb_rd_d             = mem_rd_q;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ex_ctrl_q   <= IdExBubble;
            ex_alu_op_q <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_rd_q     <= '0;
            mem_ctrl_q  <= ExMemBubble;
            mem_rd_q    <= '0;
            wb_ctrl_q   <= MemWbBubble;
            wb_rd_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_ctrl_q   <= ex_ctrl_d;
            ex_alu_op_q <= ex_alu_op_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            ex_rd_q     <= ex_rd_d;
            mem_ctrl_q  <= mem_ctrl_d;
            mem_rd_q    <= mem_rd_d;
            wb_ctrl_q   <= wb_ctrl_d;
            wb_rd_q     <= wb_rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    fwd_unit #(
        .REG_AW (REG_AW)
    ) u_fwd_a (
        .mem_reg_write_i (mem_ctrl_q.reg_write),
        .mem_rd_i        (mem_rd_q),
        .wb_reg_write_i  (wb_ctrl_q.reg_write),
        .wb_rd_i         (wb_rd_q),
        .rs_i            (ex_rs1_q),
        .fwd_o           (bus.fwd_a)
    );

    fwd_unit #(
        .REG_AW (REG_AW)
    ) u_fwd_b (
        .mem_reg_write_i (mem_ctrl_q.reg_write),
        .mem_rd_i        (mem_rd_q),
        .wb_reg_write_i  (wb_ctrl_q.reg_write),
        .wb_rd_i         (wb_rd_q),
        .rs_i            (ex_rs2_q),
        .fwd_o           (bus.fwd_b)
    );

    assign bus.stall         = stall;
    assign bus.ex_alu_op     = ex_alu_op_q;
    assign bus.ex_alu_src    = ex_ctrl_q.alu_src;
    assign bus.ex_branch     = ex_ctrl_q.branch;
    assign bus.ex_jump       = ex_ctrl_q.jump;
    assign bus.ex_mem_read   = ex_ctrl_q.mem_read;
    assign bus.ex_mem_write  = ex_ctrl_q.mem_write;
    assign bus.ex_mem_2_reg  = ex_ctrl_q.mem_2_reg;
    assign bus.ex_reg_write  = ex_ctrl_q.reg_write;
    assign bus.ex_rs1        = ex_rs1_q;
    assign bus.ex_rs2        = ex_rs2_q;
    assign bus.ex_rd         = ex_rd_q;
    assign bus.mem_branch    = mem_ctrl_q.branch;
    assign bus.mem_jump      = mem_ctrl_q.jump;
    assign bus.mem_mem_read  = mem_ctrl_q.mem_read;
    assign bus.mem_mem_write = mem_ctrl_q.mem_write;
    assign bus.mem_mem_2_reg = mem_ctrl_q.mem_2_reg;
    assign bus.mem_reg_write = mem_ctrl_q.reg_write;
    assign bus.mem_rd        = mem_rd_q;
    assign bus.wb_mem_2_reg  = wb_ctrl_q.mem_2_reg;
    assign bus.wb_reg_write  = wb_ctrl_q.reg_write;
    assign bus.wb_rd         = wb_rd_q;
    assign bus.stall_cnt     = stall_cnt_q;

endmodule

// File: doc/ctrl_pipe_hazard.md
Name: ctrl_pipe_hazard

Overview:
- Downstream neighbour of the decode-stage control unit.
- Carries the decoded control bundle and register addresses through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and generates the stall, bubble and flush behaviour.
- Produces EX-stage forwarding selects for the datapath muxes.

Parameters:
- REG_AW, 5, register-address width (x0..x31)
- ALU_OP_W, 2, ALUOp width
- CNT_W, 16, stall-cycle counter width

Ports:
- clk  in  1  system clock
- arst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_alu_op  in  ALU_OP_W  ALUOp from control unit
- id_alu_src, id_branch, id_jump, id_mem_read, id_mem_write, id_mem_2_reg, id_reg_write  in  1 each  control bits from control unit
- id_rs1, id_rs2, id_rd  in  REG_AW each  register fields of the ID instruction
- flush  in  1  branch/jump taken, resolved in MEM
- stall  out  1  hold PC and IF/ID (combinational)
- ex_alu_op  out  ALU_OP_W  registered ID/EX control
- ex_alu_src, ex_branch, ex_jump, ex_mem_read, ex_mem_write, ex_mem_2_reg, ex_reg_write  out  1 each  registered ID/EX control
- ex_rs1, ex_rs2, ex_rd  out  REG_AW each  registered ID/EX addresses
- mem_branch, mem_jump, mem_mem_read, mem_mem_write, mem_mem_2_reg, mem_reg_write  out  1 each  EX/MEM control
- mem_rd  out  REG_AW  EX/MEM destination
- wb_mem_2_reg, wb_reg_write  out  1 each  MEM/WB control
- wb_rd  out  REG_AW  MEM/WB destination
- fwd_a, fwd_b  out  2 each  operand forwarding select (combinational)
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset: arst_n low clears every register immediately. All registered outputs and stall_cnt read 0. A zero bundle is a bubble.
- Pipeline: each register stage has 1-cycle latency and advances every clock; there is no global enable.
  - ID/EX captures all id_* fields when id_valid=1, otherwise a bubble.
  - EX/MEM captures the EX bundle minus alu_op, alu_src, rs1 and rs2.
  - MEM/WB captures mem_2_reg, reg_write and rd.
- Operand usage:
  - rs1 is used unless id_jump=1.
  - rs2 is used when (id_alu_src=0 and id_jump=0) or id_mem_write=1.
- Load-use hazard: hz = id_valid & ex_mem_read & (ex_rd != 0) & ((use_rs1 & ex_rd == id_rs1) | (use_rs2 & ex_rd == id_rs2)).
- Stall and flush outputs:
  - stall = hz & ~flush.
  - While stall=1, ID/EX loads a bubble; EX/MEM and MEM/WB advance normally.
  - ID/EX shows a bubble for exactly one cycle per load-use pair.
- Flush:
  - flush=1 loads bubbles into ID/EX and EX/MEM at the next edge.
  - MEM/WB advances normally, so the flushing instruction itself retires.
  - Flush overrides stall.
- Forwarding, fwd_a for ex_rs1 and fwd_b for ex_rs2:
  - 2'b10 when mem_reg_write & mem_rd != 0 & mem_rd == ex_rsX.
  - Else 2'b01 when wb_reg_write & wb_rd != 0 & wb_rd == ex_rsX.
  - Else 2'b00. EX/MEM has priority.
- stall_cnt: increments on each clock with stall=1 and saturates at all-ones, with no wrap.
- x0: rd=0 never triggers a hazard or forwarding, even when reg_write=1.
- Reset mid-operation: asynchronous clear. The first edge after release samples id_* normally.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants.
  - ALUOp constants ADD=00, SUB=01, RTYPE=10.
  - FWD constants FWD_RF=00, FWD_WB=01, FWD_MEM=10.
  - a bubble constant.
- One natural sub-module, fwd_unit: pure combinational forwarding compare, instantiated once per operand (fwd_a, fwd_b).
- Pipeline registers and hazard logic stay in the top module.

Test Plan:
- Reset: hold arst_n=0 with random inputs -> all outputs 0, stall=0, stall_cnt=0. Release arst_n, feed an ALU_R bundle with rd=3 -> ex_reg_write=1 and ex_rd=3 one cycle later, wb_rd=3 three cycles later.
- Load-use: load rd=5 into ID/EX, then ID instruction with rs1=5, use_rs1=1 -> stall=1 for one cycle, ID/EX bubble, stall_cnt=1. Next cycle stall=0 and fwd_a=01 once the load reaches MEM/WB.
- x0 and store rs2: load rd=0 followed by rs1=0 -> stall=0. Store with rs2 equal to the load rd -> stall=1.
- Forward priority: mem_rd=7 and wb_rd=7, both reg_write=1, ex_rs2=7 -> fwd_b=10. Clear mem_reg_write -> fwd_b=01.
- Flush with simultaneous hazard: flush=1 while hz=1 -> stall=0. Next cycle ex_* and mem_* are all 0; wb_* carries the prior MEM bundle.
- Counter saturation: CNT_W=2, force 5 consecutive load-use stalls -> stall_cnt reads 1,2,3,3,3.
